// File: rtl/cam_stream_arbiter_pkg.sv
// Shared types and constants for the CAM serializer arbiter.
// Packet constants are also used by the heartbeat/reset producers.
package cam_arb_pkg;

  typedef enum logic {
    IDLE,
    PEND
  } cam_arb_state_t;

  localparam int CAM_PKT_W = 32;
  localparam int CAM_CNT_W = 16;

  localparam logic [CAM_PKT_W-1:0] CAM_RESET_MARKER = 32'hC0DE_0000;
  localparam logic [CAM_PKT_W-1:0] CAM_HEARTBEAT    = 32'hBEA7_0001;

  // peer index k steps after ptr, wrapping within 1..n-1
  function automatic int cam_arb_peer(int ptr, int k, int n);
    return ((ptr - 1 + k) % (n - 1)) + 1;
  endfunction

endpackage

// File: rtl/cam_stream_arbiter_if.sv
// Requester and serializer handshake bundle for cam_stream_arbiter.
// master = producers/serializer side, slave = arbiter side.
interface cam_stream_arbiter_if
  import cam_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int PKT_W   = CAM_PKT_W
);

  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ*PKT_W-1:0] req_data;
  logic                     ser_wr;
  logic [PKT_W-1:0]         ser_data;
  logic                     ser_busy;

  modport master (
    output req_valid,
    output req_data,
    output ser_busy,
    input  req_ready,
    input  ser_wr,
    input  ser_data
  );

  modport slave (
    input  req_valid,
    input  req_data,
    input  ser_busy,
    output req_ready,
    output ser_wr,
    output ser_data
  );

endinterface

// File: rtl/cam_arb_rr_select.sv
// Winner select: requester 0 strict priority, peers round-robin
// starting one past rr_ptr.
module cam_arb_rr_select
  import cam_arb_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic [IDX_W-1:0]   winner,
  output logic               any_valid
);

  logic found;
  int   idx;

  always_comb begin
    winner    = '0;
    any_valid = |req_valid;
    found     = req_valid[0];
    idx       = 0;
    for (int k = 1; k < NUM_REQ; k++) begin
      idx = cam_arb_peer(int'(rr_ptr), k, NUM_REQ);
      if (!found && req_valid[idx]) begin
        winner = IDX_W'(idx);
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cam_stream_arbiter.sv
// Arbitrates packet sources onto the single CAM serializer.
// Build with CAM_ARB_STATS_EN to get per-requester accept counters.
module cam_stream_arbiter
  import cam_arb_pkg::*;
#(
  parameter  int NUM_REQ     = 4,
  parameter  int PKT_W       = CAM_PKT_W,
  parameter  int STALL_LIMIT = 4096,
  localparam int IDX_W       = $clog2(NUM_REQ),
  localparam int WAIT_W      = $clog2(STALL_LIMIT + 1)
) (
  input  logic                         clk_logic,
  input  logic                         system_reset_n,
  input  logic                         enable,
  cam_stream_arbiter_if.slave          bus,
  output logic [IDX_W-1:0]             grant_id,
  output logic                         pending,
  output logic                         stall_flag,
  input  logic                         stall_clear,
  output logic [NUM_REQ*CAM_CNT_W-1:0] accept_count
);

  cam_arb_state_t    state;
  logic [PKT_W-1:0]  hold;
  logic [IDX_W-1:0]  rr_ptr;
  logic [WAIT_W-1:0] wait_cnt;
  logic [IDX_W-1:0]  winner;
  logic              any_valid;
  logic              xfer;
  logic              stall_set;

  cam_arb_rr_select #(
    .NUM_REQ (NUM_REQ)
  ) u_sel (
    .req_valid (bus.req_valid),
    .rr_ptr    (rr_ptr),
    .winner    (winner),
    .any_valid (any_valid)
  );

  always_comb begin
    bus.req_ready = '0;
    if (state == IDLE && enable && any_valid)
      bus.req_ready[winner] = 1'b1;
  end

  assign xfer         = |(bus.req_valid & bus.req_ready);
  assign bus.ser_wr   = (state == PEND) && !bus.ser_busy;
  assign bus.ser_data = hold;
  assign pending      = (state == PEND);
  assign stall_set    = (state == PEND) && bus.ser_busy
                     && (wait_cnt == WAIT_W'(STALL_LIMIT - 1));

  always_ff @(posedge clk_logic or negedge system_reset_n) begin
    if (!system_reset_n) begin
      state      <= IDLE;
      hold       <= '0;
      grant_id   <= '0;
      rr_ptr     <= IDX_W'(NUM_REQ - 1);
      wait_cnt   <= '0;
      stall_flag <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (xfer) begin
            hold     <= bus.req_data[winner*PKT_W +: PKT_W];
            grant_id <= winner;
            if (winner != '0)
              rr_ptr <= winner;
            state    <= PEND;
          end
        end
        PEND: begin
          if (bus.ser_wr) begin
            state    <= IDLE;
            wait_cnt <= '0;
          end else if (wait_cnt != WAIT_W'(STALL_LIMIT)) begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
      // a new stall event beats a same-cycle clear
      if (stall_set)
        stall_flag <= 1'b1;
      else if (stall_clear)
        stall_flag <= 1'b0;
    end
  end

`ifdef CAM_ARB_STATS_EN
  logic [NUM_REQ-1:0][CAM_CNT_W-1:0] cnt;

  always_ff @(posedge clk_logic or negedge system_reset_n) begin
    if (!system_reset_n)
      cnt <= '0;
    else if (xfer)
      cnt[winner] <= cnt[winner] + 1'b1;
  end

  assign accept_count = cnt;
`else
  assign accept_count = '0;
`endif

endmodule

// File: tb/tb_cam_stream_arbiter.sv
// Scoreboard bench for cam_stream_arbiter with a queue-based
// round-robin reference model.
module tb_cam_stream_arbiter;

  localparam int N  = 4;
  localparam int W  = 32;
  localparam int SL = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic enable = 1'b0;
  logic stall_clear = 1'b0;
  logic [1:0] grant_id;
  logic pending;
  logic stall_flag;
  logic [N*16-1:0] accept_count;

  always #5 clk = ~clk;

  cam_stream_arbiter_if #(.NUM_REQ(N), .PKT_W(W)) bus ();

  cam_stream_arbiter #(
    .NUM_REQ     (N),
    .PKT_W       (W),
    .STALL_LIMIT (SL)
  ) dut (
    .clk_logic      (clk),
    .system_reset_n (rst_n),
    .enable         (enable),
    .bus            (bus),
    .grant_id       (grant_id),
    .pending        (pending),
    .stall_flag     (stall_flag),
    .stall_clear    (stall_clear),
    .accept_count   (accept_count)
  );

  typedef struct {
    logic [W-1:0] d;
    int           id;
  } exp_t;

  int   total = 0;
  int   bad = 0;
  exp_t exp_q[$];
  int   glog[$];
  int   order[$] = '{1, 2, 3};
  bit   m_pend;
  int   m_wait;
  bit   m_stall;
  int   m_cnt[N];

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // reference model: compares registered outputs, then the
  // combinational handshake, then advances to the next edge
  logic [N-1:0] exp_rdy;
  int           w;
  bit           set_ev;

  always @(negedge clk) begin
    if (!rst_n) begin
      m_pend  = 0;
      m_wait  = 0;
      m_stall = 0;
      order   = '{1, 2, 3};
      exp_q.delete();
      foreach (m_cnt[i]) m_cnt[i] = 0;
    end else begin
      chk("pending", pending, m_pend);
      chk("stall_flag", stall_flag, m_stall);
      exp_rdy = '0;
      w = -1;
      if (!m_pend && enable) begin
        if (bus.req_valid[0]) w = 0;
        else foreach (order[k])
          if (w < 0 && bus.req_valid[order[k]]) w = order[k];
        if (w >= 0) exp_rdy[w] = 1'b1;
      end
      chk("req_ready", bus.req_ready, exp_rdy);
      chk("ser_wr", bus.ser_wr, m_pend && !bus.ser_busy);
      set_ev = 0;
      if (m_pend) begin
        if (bus.ser_busy) begin
          if (m_wait < SL) begin
            m_wait++;
            if (m_wait == SL) set_ev = 1;
          end
        end else begin
          m_pend = 0;
          m_wait = 0;
        end
      end else if (w >= 0) begin
        exp_q.push_back('{bus.req_data[w*W +: W], w});
        m_pend = 1;
        m_cnt[w] = (m_cnt[w] + 1) % 65536;
        if (w != 0) begin
          while (order[0] != w) order = {order[1:$], order[0]};
          order = {order[1:$], order[0]};
        end
      end
      if (set_ev) m_stall = 1;
      else if (stall_clear) m_stall = 0;
    end
  end

  // monitor: pops one expected packet per ser_wr pulse
  exp_t e;
  always @(negedge clk) begin
    if (rst_n && bus.ser_wr) begin
      if (exp_q.size() == 0) begin
        chk("ser_wr_unexpected", bus.ser_wr, 1'b0);
      end else begin
        e = exp_q.pop_front();
        chk("ser_data", bus.ser_data, e.d);
        chk("grant_id", grant_id, e.id);
        glog.push_back(int'(grant_id));
      end
    end
  end

  task automatic cyc(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_lane(int i, bit v, logic [W-1:0] d);
    bus.req_valid[i] = v;
    bus.req_data[i*W +: W] = d;
  endtask

  task automatic do_reset();
    bus.req_valid = '0;
    rst_n = 1'b0;
    cyc(2);
    rst_n = 1'b1;
    cyc(1);
  endtask

  task automatic chk_counts(string name);
    for (int i = 0; i < N; i++) begin
`ifdef CAM_ARB_STATS_EN
      chk(name, accept_count[i*16 +: 16], m_cnt[i]);
`else
      chk(name, accept_count[i*16 +: 16], 0);
`endif
    end
  endtask

  bit busy_mode = 0;

  initial begin
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.ser_busy  = 1'b0;
    #2;
    chk("rst_pending", pending, 0);
    chk("rst_grant", grant_id, 0);
    chk("rst_stall", stall_flag, 0);
    chk("rst_ser_wr", bus.ser_wr, 0);
    chk("rst_ser_data", bus.ser_data, 0);
    chk("rst_count", accept_count, 0);
    cyc(2);
    rst_n = 1'b1;
    enable = 1'b1;
    cyc(1);

    // single requester 2
    glog.delete();
    set_lane(2, 1, 32'hC03C_5A80);
    cyc(1);
    bus.req_valid = '0;
    cyc(3);
    chk("t1_grants", glog.size(), 1);
    if (glog.size() > 0) chk("t1_id", glog[0], 2);

    // peers held: 1,2,3,1,2,3
    do_reset();
    glog.delete();
    for (int i = 1; i < N; i++) set_lane(i, 1, 32'hA000_0000 + i);
    cyc(12);
    bus.req_valid = '0;
    cyc(3);
    chk("rot_count", glog.size(), 6);
    for (int i = 0; i < 6 && i < glog.size(); i++)
      chk("rot_order", glog[i], (i % 3) + 1);

    // requester 0 preempts, rotation resumes at next peer
    glog.delete();
    for (int i = 1; i < N; i++) set_lane(i, 1, 32'hB000_0000 + i);
    cyc(1);
    set_lane(0, 1, 32'h0000_0BAD);
    cyc(2);
    bus.req_valid[0] = 1'b0;
    cyc(5);
    bus.req_valid = '0;
    cyc(3);
    chk("pre_count", glog.size(), 4);
    if (glog.size() == 4) begin
      chk("pre_0", glog[0], 1);
      chk("pre_1", glog[1], 0);
      chk("pre_2", glog[2], 2);
      chk("pre_3", glog[3], 3);
    end

    // busy for 10 cycles: no issue, no ready, stall sets
    glog.delete();
    bus.ser_busy = 1'b1;
    set_lane(1, 1, 32'h1234_5678);
    cyc(1);
    bus.req_valid = 4'b1110;
    cyc(10);
    bus.req_valid = '0;
    chk("busy_no_issue", glog.size(), 0);
    chk("busy_pending", pending, 1);
    bus.ser_busy = 1'b0;
    cyc(3);
    chk("busy_one_issue", glog.size(), 1);
    chk("stall_sticky", stall_flag, 1);
    stall_clear = 1'b1;
    cyc(1);
    stall_clear = 1'b0;
    cyc(1);
    chk("stall_cleared", stall_flag, 0);

    // reset mid-PEND, then requester 1 is next peer
    glog.delete();
    bus.ser_busy = 1'b1;
    set_lane(1, 1, 32'h5555_0001);
    cyc(1);
    bus.req_valid = '0;
    cyc(2);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_pending", pending, 0);
    chk("mid_rst_ser_wr", bus.ser_wr, 0);
    chk("mid_rst_grant", grant_id, 0);
    chk("mid_rst_data", bus.ser_data, 0);
    cyc(2);
    rst_n = 1'b1;
    bus.ser_busy = 1'b0;
    cyc(1);
    chk("mid_rst_no_issue", glog.size(), 0);
    for (int i = 1; i < N; i++) set_lane(i, 1, 32'h6666_0000 + i);
    cyc(1);
    bus.req_valid = '0;
    cyc(3);
    chk("mid_rst_next", glog.size() > 0 ? glog[0] : -1, 1);

    // counters: 3 from requester 0, 2 from requester 3
    do_reset();
    set_lane(0, 1, CAM_HB());
    cyc(5);
    bus.req_valid = '0;
    set_lane(3, 1, 32'h3333_3333);
    cyc(4);
    bus.req_valid = '0;
    cyc(3);
`ifdef CAM_ARB_STATS_EN
    chk("cnt0", accept_count[15:0], 3);
    chk("cnt3", accept_count[63:48], 2);
`else
    chk("cnt0", accept_count[15:0], 0);
    chk("cnt3", accept_count[63:48], 0);
`endif
    chk_counts("cnt_model");

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      enable = ($urandom_range(0, 9) != 0);
      for (int i = 0; i < N; i++)
        set_lane(i, ($urandom_range(0, 3) == 0), $urandom);
      if ($urandom_range(0, 15) == 0) busy_mode = ~busy_mode;
      bus.ser_busy = busy_mode ? ($urandom_range(0, 7) != 0)
                               : ($urandom_range(0, 3) == 0);
      stall_clear = ($urandom_range(0, 19) == 0);
      cyc(1);
    end
    bus.req_valid = '0;
    bus.ser_busy = 1'b0;
    stall_clear = 1'b0;
    cyc(4);
    chk("drain", exp_q.size(), 0);
    chk_counts("cnt_final");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  function automatic logic [W-1:0] CAM_HB();
    return cam_arb_pkg::CAM_HEARTBEAT;
  endfunction

endmodule

// File: doc/cam_stream_arbiter.md
# cam_stream_arbiter

Shares the single CAM serializer between several 32-bit packet sources: bus capture, heartbeat, reset marker and status/telemetry. It sits between the packet producers and the serializer's `wr_i`/`busy` port. It grants one requester at a time, buffers one packet, and issues it when the serializer is free. Requester 0 has strict priority; the rest are served round-robin.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters, 2..8.
- `PKT_W`, 32: packet width.
- `STALL_LIMIT`, 4096: cycles a held packet may wait on `ser_busy` before `stall_flag` sets.

Ports:
- `clk_logic`  in  1  sole clock.
- `system_reset_n`  in  1  reset, asynchronous assert, active-low.
- `enable`  in  1  low blocks new grants; a held packet is still issued.
- `req_valid`  in  NUM_REQ  per-requester packet valid.
- `req_data`  in  NUM_REQ*PKT_W  requester i occupies `[i*PKT_W +: PKT_W]`.
- `req_ready`  out  NUM_REQ  one-hot accept; transfer happens when `req_valid[i] & req_ready[i]`.
- `ser_wr`  out  1  write strobe to the serializer.
- `ser_data`  out  PKT_W  packet to the serializer.
- `ser_busy`  in  1  serializer busy.
- `grant_id`  out  $clog2(NUM_REQ)  index of the last accepted requester.
- `pending`  out  1  a packet is held.
- `stall_flag`  out  1  sticky; the held packet waited at least `STALL_LIMIT` cycles.
- `stall_clear`  in  1  clears `stall_flag`.
- `accept_count`  out  NUM_REQ*16  per-requester accepted-packet counters. Present only with the stats macro.

## Operation
States:
- `IDLE`: no packet held.
  - `req_ready` is non-zero only if `enable` is high and some `req_valid` is high.
  - Winner selection:
    - requester 0 if it is valid;
    - otherwise the first valid index scanning upward, with wrap, from `rr_ptr+1` over 1..NUM_REQ-1.
  - On a transfer: `req_data[winner]` is latched into the hold register, `grant_id` becomes the winner, `rr_ptr` becomes the winner (only when winner ≠ 0), and the state moves to `PEND`.
- `PEND`:
  - `req_ready` is 0.
  - `ser_wr = !ser_busy` (combinational). `ser_data` is always the hold register.
  - When `ser_wr` is high the state returns to `IDLE` on the next edge.
  - `wait_cnt` increments each cycle spent in `PEND` with `ser_busy` high, and saturates at `STALL_LIMIT`. Reaching the limit sets `stall_flag`.
  - `wait_cnt` clears when the state returns to `IDLE`.

Rules:
- `stall_clear` and a set event in the same cycle: set wins.
- `pending` is high exactly when the state is `PEND`.
- Simultaneous valids: requester 0 always wins. Requesters 1..N-1 rotate, and none waits more than NUM_REQ-2 grants among its peers.
- `rr_ptr` range is 1..NUM_REQ-1. Its reset value is NUM_REQ-1, so requester 1 is first.
- A requester dropping `req_valid` without a handshake is legal; it is simply not granted.
- Reset mid-`PEND` drops the held packet with no `ser_wr`.

Reset values: state `IDLE`, all outputs 0, hold register 0, `rr_ptr` = NUM_REQ-1, counters 0.

## Timing
- Grant cycle T: `req_ready` is combinational from the state, `enable` and `req_valid`.
- Issue cycle: T+1 at the earliest, if `ser_busy` is low. Request-to-issue latency is 1 cycle.
- Next grant: T+2 at the earliest. Peak throughput is 1 packet per 2 cycles, which exceeds the serializer's ≥32-cycle packet time.
- `ser_wr` is a single-cycle pulse per packet; each packet is issued exactly once.
- `accept_count[i]` increments on the edge ending the handshake cycle and wraps at 16 bits.

## Configuration
- `CAM_ARB_STATS_EN` defined: the `accept_count` counters are built.
- Undefined: `accept_count` is driven to constant 0 and no counter flops exist. Arbitration is identical in both cases.

## Structure
- Package `cam_arb_pkg` holds:
  - the state enum `cam_arb_state_t` (`IDLE`, `PEND`);
  - `CAM_PKT_W` = 32;
  - `CAM_CNT_W` = 16;
  - the reset-marker and heartbeat packet constants shared with the producers.
- Sub-module `cam_arb_rr_select` is combinational. Inputs: `req_valid`, `rr_ptr`. Outputs: `winner`, `any_valid`. The state, hold register and counters live in the top.

## Test plan
- Single requester 2 sends 0xC03C_5A80 with `ser_busy`=0 → `req_ready[2]` at T, `ser_wr`=1 with `ser_data`=0xC03C_5A80 at T+1, `grant_id`=2.
- Requesters 1, 2, 3 held valid continuously → grant order 1,2,3,1,2,3. Adding requester 0 preempts the next grant, then rotation resumes at the next peer in order.
- `ser_busy` held high for 10 cycles after a grant → `pending`=1, no `ser_wr`, no `req_ready`. Busy falls → exactly one `ser_wr` pulse.
- `STALL_LIMIT`=8 with `ser_busy` held high for 8 cycles → `stall_flag` set and stays set after issue. `stall_clear` pulse → 0.
- `system_reset_n` pulsed low during `PEND` → all outputs 0 immediately, no `ser_wr`, and requester 1 is next among the peers.
- With `CAM_ARB_STATS_EN`, 3 packets from requester 0 and 2 from requester 3 → `accept_count` fields 3,0,0,2. Without the macro → all 0.
